// File: rtl/info_serializer_if.sv
// Word-in / beat-out handshake bundle for info_serializer.
// The serializer takes the slave view; the upstream/downstream environment takes the master view.
interface info_serializer_if #(
   parameter int DATA_W = 128,
   parameter int OUT_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_last;
   logic              crc_ok;
   logic              busy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, crc_ok, busy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, crc_ok, busy
   );
endinterface

// File: rtl/info_serializer.sv
// Streams a decoded information word out MSB-first as OUT_W-bit beats with a last marker.
// Optional CRC-8 word check enabled by defining INFO_SERIALIZER_CRC_CHECK_EN.
//
// state | meaning
// IDLE  | no word held, ready for a new word
// SHIFT | word held, beats being presented on out_data
module info_serializer #(
   parameter int DATA_W = 128,
   parameter int OUT_W  = 8
) (
   input logic              clk,
   input logic              rst,
   info_serializer_if.slave bus
);
   localparam int BEATS = DATA_W / OUT_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(BEATS - 2);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_beat_cnt;
   logic              r_out_valid;
   logic              r_out_last;
   logic              r_crc_ok;

   logic w_adv;
   logic w_fin_hs;
   logic w_load;
   logic w_crc_ok;

   assign w_adv        = r_out_valid && bus.out_ready;
   assign w_fin_hs     = w_adv && r_out_last;
   assign bus.in_ready = (r_state == IDLE) || w_fin_hs;
   assign w_load       = bus.in_valid && bus.in_ready;

`ifdef INFO_SERIALIZER_CRC_CHECK_EN
   // CRC-8 poly 0x07, init 0, MSB-first, over everything above the check byte
   function automatic logic [7:0] crc8(input logic [DATA_W-1:8] d);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = DATA_W - 1; i >= 8; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   assign w_crc_ok = (crc8(bus.in_data[DATA_W-1:8]) == bus.in_data[7:0]);
`else
   assign w_crc_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_beat_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_crc_ok    <= 1'b0;
      end else if (w_load) begin
         // covers both a fresh start from IDLE and a bubble-free reload on the final beat
         r_state     <= SHIFT;
         r_shift     <= bus.in_data;
         r_beat_cnt  <= '0;
         r_out_valid <= 1'b1;
         r_out_last  <= (BEATS == 1);
         r_crc_ok    <= w_crc_ok;
      end else if (w_adv) begin
         r_shift <= {r_shift[DATA_W-OUT_W-1:0], {OUT_W{1'b0}}};
         if (r_out_last) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_crc_ok    <= 1'b0;
         end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_out_last <= (r_beat_cnt == CNT_PRELAST);
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_shift[DATA_W-1 -: OUT_W];
   assign bus.out_last  = r_out_last;
   assign bus.crc_ok    = r_crc_ok;
   assign bus.busy      = (r_state == SHIFT);
endmodule

// File: tb/tb_info_serializer.sv
// Randomized and directed bench for info_serializer against a queue-based beat model.
module tb_info_serializer;
   localparam int DATA_W = 128;
   localparam int OUT_W  = 8;
   localparam int BEATS  = DATA_W / OUT_W;
`ifdef INFO_SERIALIZER_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   typedef struct {
      logic [OUT_W-1:0] d;
      logic             last;
      logic             crc;
   } beat_t;

   logic clk;
   logic rst;
   info_serializer_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

   info_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int               n_chk;
   int               n_pass;
   int               hs_cnt;
   int               last_cnt;
   logic             last_crc;
   beat_t            exp_q[$];
   logic             stalled;
   logic [OUT_W-1:0] held_data;
   logic             held_last;
   logic             held_crc;
   int               cyc_idx;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // CRC as remainder of polynomial long division of msg*x^8 by x^8+x^2+x+1
   function automatic logic [7:0] ref_crc(input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
      r = {w[DATA_W-1:8], 8'h00};
      for (int i = DATA_W - 1; i >= 8; i--)
         if (r[i]) r = r ^ (DATA_W'(9'h107) << (i - 8));
      return r[7:0];
   endfunction

   function automatic logic [DATA_W-1:0] rand_word();
      logic [DATA_W-1:0] w;
      w = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(1) == 1) w[7:0] = ref_crc(w);
      return w;
   endfunction

   task automatic push_word(input logic [DATA_W-1:0] w);
      beat_t e;
      for (int k = 0; k < BEATS; k++) begin
         e.d    = OUT_W'(w >> (DATA_W - (k + 1) * OUT_W));
         e.last = (k == BEATS - 1);
         e.crc  = CRC_EN ? (ref_crc(w) == w[7:0]) : 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic cyc(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, output logic took);
      logic  exp_rdy;
      beat_t e;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      #1;
      cyc_idx++;
      exp_rdy = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      chk("busy", bus.busy, exp_q.size() != 0);
      if (stalled) begin
         chk("stall_data", bus.out_data, held_data);
         chk("stall_last", bus.out_last, held_last);
         chk("stall_crc", bus.crc_ok, held_crc);
      end
      if (bus.out_valid && exp_q.size() != 0) begin
         e = exp_q[0];
         chk("beat_data", bus.out_data, e.d);
         chk("beat_last", bus.out_last, e.last);
         if (e.last) chk("beat_crc", bus.crc_ok, e.crc);
         if (ordy) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            if (bus.out_last) begin
               last_cnt++;
               last_crc = bus.crc_ok;
            end
         end
      end
      stalled   = bus.out_valid && !ordy;
      held_data = bus.out_data;
      held_last = bus.out_last;
      held_crc  = bus.crc_ok;
      took      = iv && bus.in_ready;
      if (took) push_word(d);
   endtask

   function automatic logic ready_pat(input int mode);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc_idx % 3) == 0;
         default: return 1'($urandom_range(1));
      endcase
   endfunction

   task automatic send(input logic [DATA_W-1:0] w, input int mode);
      logic took;
      took = 1'b0;
      for (int n = 0; n < 100 && !took; n++) cyc(1'b1, w, ready_pat(mode), took);
      if (!took) chk("send_timeout", 0, 1);
   endtask

   task automatic drain(input int mode);
      logic took;
      for (int n = 0; n < 400 && exp_q.size() != 0; n++) cyc(1'b0, '0, ready_pat(mode), took);
      if (exp_q.size() != 0) chk("drain_timeout", 0, 1);
      cyc(1'b0, '0, 1'b1, took);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      chk({tag, "_out_data"}, bus.out_data, 0);
      chk({tag, "_out_last"}, bus.out_last, 0);
      chk({tag, "_crc_ok"}, bus.crc_ok, 0);
   endtask

   initial begin
      logic              took;
      logic [DATA_W-1:0] w_basic;
      logic [DATA_W-1:0] w_a;
      logic [DATA_W-1:0] w_b;
      n_chk = 0; n_pass = 0; hs_cnt = 0; last_cnt = 0; last_crc = 1'b0;
      stalled = 1'b0; held_data = '0; held_last = 1'b0; held_crc = 1'b0; cyc_idx = 0;
      w_basic = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      w_a = {BEATS{8'hA5}};
      w_b = {BEATS{8'h3C}};
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1 check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      repeat (20) cyc(1'b0, '0, 1'b1, took);

      hs_cnt = 0; last_cnt = 0;
      send(w_basic, 0);
      drain(0);
      chk("basic_beats", hs_cnt, BEATS);
      chk("basic_lasts", last_cnt, 1);

      hs_cnt = 0; last_cnt = 0;
      send(w_basic, 1);
      drain(1);
      chk("bp_beats", hs_cnt, BEATS);
      chk("bp_lasts", last_cnt, 1);

      hs_cnt = 0; last_cnt = 0;
      send(w_a, 0);
      send(w_b, 0);
      drain(0);
      chk("b2b_beats", hs_cnt, 2 * BEATS);
      chk("b2b_lasts", last_cnt, 2);

      hs_cnt = 0;
      send(w_basic, 0);
      for (int n = 0; n < 50 && hs_cnt < 6; n++) cyc(1'b0, '0, 1'b1, took);
      @(negedge clk);
      rst = 1'b1;
      #1 check_idle_outputs("midrst");
      exp_q.delete();
      stalled = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1 check_idle_outputs("post_rst");
      hs_cnt = 0;
      send(rand_word(), 0);
      drain(0);
      chk("post_rst_beats", hs_cnt, BEATS);

      send('0, 0);
      drain(0);
      chk("crc_zero", last_crc, 1);
      send(128'h1, 0);
      drain(0);
      chk("crc_one", last_crc, CRC_EN ? 1'b0 : 1'b1);

      for (int n = 0; n < 600; n++)
         cyc(1'($urandom_range(1)), rand_word(), 1'($urandom_range(3) != 0), took);
      drain(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/info_serializer.md
Name: info_serializer

Overview:
- Downstream of the polar decode info-bit extractor.
- Accepts one 128-bit decoded information word per handshake and streams it out as OUT_W-bit beats over a valid/ready interface, MSB first, with a last-beat marker.
- Optionally runs a CRC-8 integrity check over the word and reports the result alongside the final beat.

Parameters:
- DATA_W, 128, information word width; must be an integer multiple of OUT_W.
- OUT_W, 8, output beat width.
- BEATS, DATA_W/OUT_W (derived localparam, 16), beats per word.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  information word; in_data[DATA_W-1] is the first bit out.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  sink accepts the beat this cycle.
- out_data  output  OUT_W  current beat.
- out_last  output  1  high with the final beat of a word.
- crc_ok  output  1  CRC result for the word; meaningful only when out_valid && out_last.
- busy  output  1  high while a word is held (state SHIFT).

Behaviour:
- Reset values: state=IDLE, beat_cnt=0, shift register=0, out_valid=0, out_data=0, out_last=0, crc_ok=0, busy=0.
- FSM:
  - IDLE -> SHIFT on in_valid && in_ready.
  - SHIFT -> IDLE on final-beat handshake when no new word is accepted in the same cycle.
  - SHIFT -> SHIFT on final-beat handshake when a new word is accepted in the same cycle.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). Combinational from state and out_ready; no combinational path from in_valid.
- Accept: in_data is loaded into the shift register, beat_cnt=0, out_valid=1 from the next cycle. Latency from input handshake to first beat on out_data is 1 cycle.
- Beat k (0..BEATS-1) carries word[DATA_W-1-k*OUT_W -: OUT_W].
- Registered output; beat advance occurs only on out_valid && out_ready. beat_cnt increments and the shift register shifts left by OUT_W.
- Backpressure (out_valid && !out_ready): out_data, out_last, crc_ok and beat_cnt hold stable. out_valid is never withdrawn until handshaken.
- out_last = (beat_cnt==BEATS-1) while out_valid.
- Final-beat handshake with in_valid=1 loads the next word with no bubble: out_valid stays 1 and the next word's beat 0 appears the next cycle.
- Final-beat handshake with in_valid=0: out_valid=0, busy=0 next cycle.
- in_valid while in SHIFT and not at the final handshake is ignored (in_ready=0); upstream holds its data.
- beat_cnt width is clog2(BEATS). It wraps to 0 only via a new load, never by overflow.
- Reset asserted mid-word: the word is dropped and all outputs return to reset values immediately (async). No partial word resumes after reset release.

Optional Feature:
- Macro: INFO_SERIALIZER_CRC_CHECK_EN.
- Defined:
  - At accept, compute CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) over in_data[DATA_W-1:8].
  - Register crc_ok = (computed == in_data[7:0]). Held constant for the whole word.
  - CRC logic is combinational on in_data at load; there is no extra latency.
- Undefined: crc_ok is driven 1 whenever out_valid, 0 otherwise; no CRC logic is synthesised.

Test Plan:
- Basic stream: reset, in_data=128'h00112233_44556677_8899AABB_CCDDEEFF, out_ready=1. Expected: in_ready drops after accept; 16 beats 00,11,...,FF on consecutive cycles starting 1 cycle after accept; out_last only on FF; busy falls after it.
- Backpressure: same word, out_ready toggling 1,0,0,1,... Expected: out_data and out_last stable during stalls; exactly 16 handshaken beats in order, none duplicated or lost.
- Back-to-back: two words A=all 8'hA5 beats and B=all 8'h3C, in_valid held high. Expected: B accepted on the A final-beat handshake cycle; 32 contiguous beats with no out_valid gap; out_last twice.
- Reset mid-word: assert rst after beat 5 handshake. Expected: out_valid=0, busy=0, in_ready=1 immediately after reset release; the next word starts at its beat 0.
- CRC (macro defined): in_data=0 -> crc_ok=1 on last beat; in_data=128'h1 -> crc_ok=0. With the macro undefined, both give crc_ok=1.
- Idle hold: in_valid=0 for 20 cycles after reset. Expected: out_valid=0, in_ready=1, busy=0 throughout.
